// File: rtl/data_mem_responder_pkg.sv
// data_mem_responder_pkg: RV32I func3 encodings, FSM states and word/byte widths
package data_mem_responder_pkg;
  localparam int WORD_W = 32;
  localparam int BYTE_W = 8;
  localparam int WORD_BYTES = WORD_W / BYTE_W;
  localparam logic [2:0] F3_LB = 3'd0, F3_LH = 3'd1, F3_LW = 3'd2, F3_LBU = 3'd4, F3_LHU = 3'd5;
  localparam logic [2:0] F3_SB = 3'd0, F3_SH = 3'd1, F3_SW = 3'd2;
  typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_t;
  // access length minus one, in bytes (only meaningful for legal func3)
  function automatic logic [1:0] nbm1(input logic [2:0] f3);
    return f3[1:0] == 2'd0 ? 2'd0 : f3[1:0] == 2'd1 ? 2'd1 : 2'd3;
  endfunction
  function automatic logic [WORD_BYTES-1:0] size_mask(input logic [2:0] f3);
    return f3[1:0] == 2'd0 ? 4'b0001 : f3[1:0] == 2'd1 ? 4'b0011 : 4'b1111;
  endfunction
  function automatic logic legal(input logic wr, input logic [2:0] f3);
    return wr ? f3 inside {F3_SB, F3_SH, F3_SW} : f3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU};
  endfunction
endpackage

// File: rtl/data_mem_responder_if.sv
// data_mem_responder_if: request/response bus between execute stage (master) and responder (slave)
//   req_valid/req_ready handshake, req_write, req_func3, req_addr, req_wdata;
//   rsp_valid pulse with rsp_rdata and rsp_fault
interface data_mem_responder_if
  import data_mem_responder_pkg::*;
#(
  parameter int ADDR_W = 32
);
  logic req_valid, req_ready, req_write;
  logic [2:0] req_func3;
  logic [ADDR_W-1:0] req_addr;
  logic [WORD_W-1:0] req_wdata, rsp_rdata;
  logic rsp_valid, rsp_fault;
  modport master (
    output req_valid, req_write, req_func3, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_fault
  );
  modport slave (
    input  req_valid, req_write, req_func3, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_fault
  );
endinterface

// File: rtl/data_mem_responder_lane_align.sv
// lane_align: store lane shift/byte enables and load byte gather/extension across two words
//   func3_i, off_i: access size/sign and byte offset; wdata_i: right-aligned store data
//   wlo_o/belo_o, whi_o/behi_o: store data and byte enables for low and next word
//   lo_i, hi_i: low and next word read data; rdata_o: extended load result
module lane_align
  import data_mem_responder_pkg::*;
(
  input  logic [2:0] func3_i,
  input  logic [1:0] off_i,
  input  logic [WORD_W-1:0] wdata_i,
  input  logic [WORD_W-1:0] lo_i,
  input  logic [WORD_W-1:0] hi_i,
  output logic [WORD_W-1:0] wlo_o,
  output logic [WORD_W-1:0] whi_o,
  output logic [WORD_BYTES-1:0] belo_o,
  output logic [WORD_BYTES-1:0] behi_o,
  output logic [WORD_W-1:0] rdata_o
);
  logic [2*WORD_W-1:0] wsh;
  logic [2*WORD_BYTES-1:0] be;
  logic [WORD_W-1:0] rsh;
  assign wsh = {{WORD_W{1'b0}}, wdata_i} << (BYTE_W * off_i);
  assign be = {{WORD_BYTES{1'b0}}, size_mask(func3_i)} << off_i;
  assign {whi_o, wlo_o} = wsh;
  assign {behi_o, belo_o} = be;
  assign rsh = WORD_W'({hi_i, lo_i} >> (BYTE_W * off_i));
  assign rdata_o = func3_i == F3_LB  ? {{24{rsh[7]}}, rsh[7:0]} :
                   func3_i == F3_LH  ? {{16{rsh[15]}}, rsh[15:0]} :
                   func3_i == F3_LBU ? {24'b0, rsh[7:0]} :
                   func3_i == F3_LHU ? {16'b0, rsh[15:0]} : rsh;
endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: RV32I data memory with misaligned split accesses and fault detection
//   clk: clock; reset: asynchronous active-low reset
//   bus: slave side of data_mem_responder_if (request handshake, one-cycle response pulse)
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int ADDR_W = 32
) (
  input logic clk,
  input logic reset,
  data_mem_responder_if.slave bus
);
  localparam int AW = DEPTH_WORDS > 1 ? $clog2(DEPTH_WORDS) : 1;
  state_t st_q;
  logic wr_q, cross_q, fault_q, rsp_valid_q, rsp_fault_q;
  logic [2:0] f3_q;
  logic [1:0] off_q;
  logic [AW-1:0] widx_q, ridx;
  logic [WORD_W-1:0] wdata_q, lo_q, rd_q, rsp_rdata_q, wlo, whi, wd, ld;
  logic [WORD_BYTES-1:0] belo, behi, be;
  logic [ADDR_W:0] last_d;
  logic fault_d, cross_d, acc;
  logic [WORD_W-1:0] mem [DEPTH_WORDS];
  // extra top bit keeps an access at the very top of the address space from wrapping into range
  assign last_d = {1'b0, bus.req_addr} + (ADDR_W+1)'(nbm1(bus.req_func3));
  assign fault_d = !legal(bus.req_write, bus.req_func3) || last_d[ADDR_W:2] >= (ADDR_W-1)'(DEPTH_WORDS);
  assign cross_d = 3'(bus.req_addr[1:0]) + 3'(nbm1(bus.req_func3)) > 3'd3;
  assign acc = st_q == ACC0 || st_q == ACC1;
  assign ridx = st_q == ACC1 ? widx_q + AW'(1) : widx_q;
  assign wd = st_q == ACC1 ? whi : wlo;
  assign be = st_q == ACC1 ? behi : belo;
  assign bus.req_ready = st_q == IDLE;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_fault = rsp_fault_q;
  // in RESP the read register holds the low word for single-word accesses, the high word after ACC1
  lane_align u_lane_align (
    .func3_i(f3_q),
    .off_i(off_q),
    .wdata_i(wdata_q),
    .lo_i(cross_q ? lo_q : rd_q),
    .hi_i(rd_q),
    .wlo_o(wlo),
    .whi_o(whi),
    .belo_o(belo),
    .behi_o(behi),
    .rdata_o(ld)
  );
  always_ff @(posedge clk)
    if (acc) begin
      for (int i = 0; i < WORD_BYTES; i++)
        if (wr_q && be[i]) mem[ridx][i*BYTE_W +: BYTE_W] <= wd[i*BYTE_W +: BYTE_W];
      rd_q <= mem[ridx];
    end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      st_q <= IDLE;
      wr_q <= 1'b0;
      cross_q <= 1'b0;
      fault_q <= 1'b0;
      f3_q <= '0;
      off_q <= '0;
      widx_q <= '0;
      wdata_q <= '0;
      lo_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_fault_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      rsp_fault_q <= 1'b0;
      rsp_rdata_q <= '0;
      case (st_q)
        IDLE: if (bus.req_valid) begin
          wr_q <= bus.req_write;
          f3_q <= bus.req_func3;
          off_q <= bus.req_addr[1:0];
          widx_q <= bus.req_addr[AW+1:2];
          wdata_q <= bus.req_wdata;
          cross_q <= cross_d;
          fault_q <= fault_d;
          st_q <= fault_d ? RESP : ACC0;
        end
        ACC0: st_q <= cross_q ? ACC1 : RESP;
        ACC1: begin
          lo_q <= rd_q;
          st_q <= RESP;
        end
        RESP: begin
          rsp_valid_q <= 1'b1;
          rsp_fault_q <= fault_q;
          rsp_rdata_q <= fault_q || wr_q ? '0 : ld;
          st_q <= IDLE;
        end
        default: st_q <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: directed self-checking bench for data_mem_responder
module tb_data_mem_responder;
  import data_mem_responder_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_cmp = 0, n_bad = 0, n_acc, n_rsp, pulses;
  logic acc;
  logic [2:0] bf [4] = '{F3_LW, F3_LW, F3_LW, F3_LB};
  logic [31:0] ba [4] = '{32'h100, 32'h0FE, 32'h1000, 32'h103};
  logic [32:0] bexp [4] = '{{1'b0, 32'h5AEF1180}, {1'b0, 32'h11803344}, {1'b1, 32'h0}, {1'b0, 32'h0000005A}};

  data_mem_responder_if #(.ADDR_W(32)) bus ();
  data_mem_responder #(.DEPTH_WORDS(1024), .ADDR_W(32)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [32:0] obs, input logic [32:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic w, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    bus.req_write = w;
    bus.req_func3 = f3;
    bus.req_addr = a;
    bus.req_wdata = wd;
  endtask

  task automatic xfer(input string tag, input logic w, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] wd, input logic ef, input logic [31:0] er, input int el);
    int lat = 0;
    int busy = 0;
    @(negedge clk);
    chk({tag, ".ready"}, 33'(bus.req_ready), 33'd1);
    drive(w, f3, a, wd);
    bus.req_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    drive(~w, 3'd7, ~a, ~wd);
    do begin
      @(negedge clk);
      lat++;
      if (!bus.req_ready) busy++;
    end while (!bus.rsp_valid && lat < 20);
    chk({tag, ".lat"}, 33'(lat), 33'(el));
    chk({tag, ".busy"}, 33'(busy), 33'(el - 1));
    chk({tag, ".rsp"}, {bus.rsp_fault, bus.rsp_rdata}, {ef, er});
    @(negedge clk);
    chk({tag, ".after"}, {bus.rsp_valid | bus.rsp_fault, bus.rsp_rdata}, 33'd0);
  endtask

  initial begin
    bus.req_valid = 1'b0;
    drive(1'b0, 3'd0, 32'd0, 32'd0);
    #2 reset = 1'b0;
    #10;
    chk("rst.ready", 33'(bus.req_ready), 33'd1);
    chk("rst.rsp", {bus.rsp_valid | bus.rsp_fault, bus.rsp_rdata}, 33'd0);
    @(negedge clk);
    reset = 1'b1;
    xfer("sw100", 1, F3_SW, 32'h100, 32'hDEADBEEF, 0, 32'h0, 3);
    xfer("lw100", 0, F3_LW, 32'h100, 32'h0, 0, 32'hDEADBEEF, 3);
    xfer("lb103", 0, F3_LB, 32'h103, 32'h0, 0, 32'hFFFFFFDE, 3);
    xfer("lbu103", 0, F3_LBU, 32'h103, 32'h0, 0, 32'h000000DE, 3);
    xfer("lh102", 0, F3_LH, 32'h102, 32'h0, 0, 32'hFFFFDEAD, 3);
    xfer("lhu102", 0, F3_LHU, 32'h102, 32'h0, 0, 32'h0000DEAD, 3);
    xfer("lb100", 0, F3_LB, 32'h100, 32'h0, 0, 32'hFFFFFFEF, 3);
    xfer("swFC", 1, F3_SW, 32'h0FC, 32'hAABBCCDD, 0, 32'h0, 3);
    xfer("swFE", 1, F3_SW, 32'h0FE, 32'h11223344, 0, 32'h0, 4);
    xfer("lwFE", 0, F3_LW, 32'h0FE, 32'h0, 0, 32'h11223344, 4);
    xfer("lwFC", 0, F3_LW, 32'h0FC, 32'h0, 0, 32'h3344CCDD, 3);
    xfer("lw100b", 0, F3_LW, 32'h100, 32'h0, 0, 32'hDEAD1122, 3);
    xfer("lh101", 0, F3_LH, 32'h101, 32'h0, 0, 32'hFFFFAD11, 3);
    xfer("lhuFF", 0, F3_LHU, 32'h0FF, 32'h0, 0, 32'h00002233, 4);
    xfer("lwFD", 0, F3_LW, 32'h0FD, 32'h0, 0, 32'h223344CC, 4);
    xfer("sh102", 1, F3_SH, 32'h102, 32'h1234BEEF, 0, 32'h0, 3);
    xfer("sb100", 1, F3_SB, 32'h100, 32'h12345680, 0, 32'h0, 3);
    xfer("sw104", 1, F3_SW, 32'h104, 32'h0, 0, 32'h0, 3);
    xfer("sh103", 1, F3_SH, 32'h103, 32'h7777A55A, 0, 32'h0, 4);
    xfer("lw100c", 0, F3_LW, 32'h100, 32'h0, 0, 32'h5AEF1180, 3);
    xfer("lw104", 0, F3_LW, 32'h104, 32'h0, 0, 32'h000000A5, 3);
    xfer("ld_f3", 0, 3'd3, 32'h100, 32'h0, 1, 32'h0, 2);
    xfer("st_f3", 1, 3'd3, 32'h100, 32'hFFFFFFFF, 1, 32'h0, 2);
    xfer("st_f4", 1, 3'd4, 32'h100, 32'hFFFFFFFF, 1, 32'h0, 2);
    xfer("ld_f6", 0, 3'd6, 32'h000, 32'h0, 1, 32'h0, 2);
    xfer("lw_oor", 0, F3_LW, 32'h1000, 32'h0, 1, 32'h0, 2);
    xfer("lw100d", 0, F3_LW, 32'h100, 32'h0, 0, 32'h5AEF1180, 3);
    xfer("swFFC", 1, F3_SW, 32'hFFC, 32'h13579BDF, 0, 32'h0, 3);
    xfer("sw_oor", 1, F3_SW, 32'hFFE, 32'hFFFFFFFF, 1, 32'h0, 2);
    xfer("lwFFC", 0, F3_LW, 32'hFFC, 32'h0, 0, 32'h13579BDF, 3);
    xfer("sw200", 1, F3_SW, 32'h200, 32'h01020304, 0, 32'h0, 3);
    xfer("sw204", 1, F3_SW, 32'h204, 32'h05060708, 0, 32'h0, 3);
    @(negedge clk);
    drive(1'b1, F3_SW, 32'h202, 32'hCAFEF00D);
    bus.req_valid = 1'b1;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
    #1;
    chk("rstmid.ready", 33'(bus.req_ready), 33'd1);
    chk("rstmid.rsp", {bus.rsp_valid | bus.rsp_fault, bus.rsp_rdata}, 33'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    pulses = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.rsp_valid) pulses++;
    end
    chk("rstmid.norsp", 33'(pulses), 33'd0);
    xfer("lw204r", 0, F3_LW, 32'h204, 32'h0, 0, 32'h05060708, 3);
    xfer("lw200r", 0, F3_LW, 32'h200, 32'h0, 0, 32'hF00D0304, 3);
    n_acc = 0;
    n_rsp = 0;
    @(negedge clk);
    drive(1'b0, bf[0], ba[0], 32'h0);
    bus.req_valid = 1'b1;
    for (int c = 0; c < 40 && n_rsp < 4; c++) begin
      if (bus.rsp_valid) begin
        chk($sformatf("b2b%0d", n_rsp), {bus.rsp_fault, bus.rsp_rdata}, bexp[n_rsp]);
        n_rsp++;
      end
      acc = bus.req_ready && bus.req_valid;
      @(posedge clk);
      #1;
      if (acc) begin
        n_acc++;
        if (n_acc < 4) drive(1'b0, bf[n_acc], ba[n_acc], 32'h0);
        else bus.req_valid = 1'b0;
      end
      @(negedge clk);
    end
    bus.req_valid = 1'b0;
    chk("b2b.nrsp", 33'(n_rsp), 33'd4);
    chk("b2b.nacc", 33'(n_acc), 33'd4);
    pulses = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.rsp_valid) pulses++;
    end
    chk("b2b.extra", 33'(pulses), 33'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024: number of 32-bit words in the internal data array.
REQ-002 Parameter ADDR_W, default 32: request address width.
REQ-003 clk  input  1: single clock; all state changes on its rising edge.
REQ-004 reset  input  1: asynchronous, active-low reset; 0 = in reset.
REQ-005 req_valid  input  1: execute stage presents a memory request.
REQ-006 req_ready  output  1: responder can accept a request this cycle.
REQ-007 req_write  input  1: 1 = store, 0 = load.
REQ-008 req_func3  input  3: RV32I load/store func3 (size and sign).
REQ-009 req_addr  input  ADDR_W: byte address, taken from the ALU result.
REQ-010 req_wdata  input  32: store data (rs2 value), right-aligned.
REQ-011 rsp_valid  output  1: one-cycle pulse; the response is complete.
REQ-012 rsp_rdata  output  32: load result, sign- or zero-extended; 0 for stores and faults.
REQ-013 rsp_fault  output  1: qualified by rsp_valid; the request was illegal or out of range.

Function
REQ-014 A request SHALL be accepted on a rising edge with req_valid=1 and req_ready=1; req_ready SHALL be 1 only in state IDLE.
REQ-015 The FSM SHALL have states IDLE, ACC0, ACC1, RESP.
- IDLE→ACC0 on acceptance.
- ACC0→ACC1 if the access crosses a word boundary, else ACC0→RESP.
- ACC1→RESP.
- RESP→IDLE.
REQ-016 The request fields SHALL be registered at acceptance; later changes on the req_* inputs SHALL have no effect on an in-flight request.
REQ-017 Legal load func3 values: 0 lb, 1 lh, 2 lw, 4 lbu, 5 lhu. Legal store func3 values: 0 sb, 1 sh, 2 sw. Any other value SHALL fault.
REQ-018 The word index is req_addr[ADDR_W-1:2]. An access whose first or last byte maps to a word index ≥ DEPTH_WORDS SHALL fault.
REQ-019 The fault decision SHALL be made at acceptance.
- A faulting request goes IDLE→RESP directly.
- It performs no array read and no array write.
- Response: rsp_fault=1, rsp_rdata=0.
REQ-020 Misaligned accesses SHALL be supported.
- A halfword at byte offset 3, or a word at offset 1..3, uses two word accesses: the low word in ACC0, the next word in ACC1.
REQ-021 Stores SHALL write only the addressed bytes, using per-byte enables.
- Split stores commit the low part in ACC0 and the high part in ACC1.
- Byte lanes outside the access SHALL be unchanged.
REQ-022 The array read SHALL have 1-cycle latency; the read data of the access state SHALL be merged into rsp_rdata in the following state.
REQ-023 Latency from the acceptance edge N:
- Aligned or single-word access: rsp_valid=1 in the cycle after edge N+2.
- Split access: after edge N+3.
- Fault: after edge N+1.
REQ-024 rsp_valid SHALL be high for exactly one cycle per accepted request.
REQ-025 rsp_rdata and rsp_fault SHALL be 0 whenever rsp_valid=0.
REQ-026 Sign extension SHALL use bit 7 (lb) or bit 15 (lh) of the assembled value; lbu and lhu SHALL zero-extend.
REQ-027 req_valid=1 while req_ready=0 SHALL be ignored; the stage above holds its request (stall).
REQ-028 A load to the same address immediately following a store SHALL return the stored data, because the store commits before the load's ACC0 read.

Reset
REQ-029 While reset=0, the block SHALL be in IDLE with req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_fault=0, asynchronously.
REQ-030 Reset mid-operation:
- An in-flight request SHALL be dropped with no response.
- A split store's ACC1 write SHALL NOT occur if reset asserts before that edge.
- The ACC0 write, if already committed, remains.
REQ-031 Array contents SHALL NOT be cleared by reset.

Structure
REQ-032 A shared package SHALL hold:
- the func3 load/store encodings;
- the FSM state encoding;
- the word/byte width constants.
REQ-033 One combinational sub-module, lane_align, SHALL handle:
- store data shifting and byte-enable generation;
- load byte selection across two words and extension.
REQ-034 The data array SHALL be inferred as single-port synchronous RAM inside data_mem_responder.

Verification
REQ-035 Store sw 0xDEADBEEF to 0x100, then lw 0x100 → rsp_rdata=0xDEADBEEF, rsp_fault=0, rsp_valid 2 cycles after acceptance.
REQ-036 After REQ-035, lb 0x103 → 0xFFFFFFDE; lbu 0x103 → 0x000000DE; lh 0x102 → 0xFFFFDEAD.
REQ-037 Store sw 0x11223344 to 0x0FE (split) → words 0xFC and 0x100 updated in bytes 2,3 and 0,1 only; lw 0x0FE → 0x11223344 with 3-cycle latency; req_ready=0 for 3 cycles.
REQ-038 Request with func3=3, or lw at byte address 4*DEPTH_WORDS → rsp_fault=1, rsp_rdata=0 one cycle after acceptance; array unchanged.
REQ-039 Assert reset=0 during ACC1 of a split store → no rsp_valid; high word unchanged; req_ready=1 immediately.
REQ-040 Back-to-back requests with req_valid held high → each accepted only in IDLE; exactly one rsp_valid per request, in order.
